// File: rtl/disk_loader_pkg.sv
// disk_loader_pkg: shared state encoding, SD block size and LBA helper for the track loader
package disk_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int SD_BLOCK_BYTES = 512;

    // First SD block of a track: tracks are stored back to back, spt blocks each
    function automatic logic [31:0] track_lba(input int spt, input logic [31:0] trk);
        return 32'(spt) * trk;
    endfunction

endpackage

// File: rtl/sd_block_seq.sv
// sd_block_seq: rd/wr handshake and sector counter for one track transfer of the selected drive
module sd_block_seq
    import disk_loader_pkg::*;
#(
    parameter int SECTORS_PER_TRACK = 13
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_lba,
    input  logic        ack,
    output logic        req,
    output logic [31:0] lba,
    output logic [3:0]  sec,
    output logic        first_fall,
    output logic        done
);

    localparam logic [3:0] LAST = 4'(SECTORS_PER_TRACK - 1);

    logic ack_d;
    logic rise;
    logic fall;

    assign rise       = ack & ~ack_d;
    assign fall       = ~ack & ack_d;
    assign first_fall = fall & (sec == 4'd0);
    assign done       = fall & ~req;

    // Advance the block address on ack rise, the RAM sector on ack fall; start reloads both
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_d <= 1'b0;
            req   <= 1'b0;
            lba   <= '0;
            sec   <= '0;
        end else begin
            ack_d <= ack;
            if (start) begin
                req <= 1'b1;
                lba <= base_lba;
                sec <= '0;
            end else begin
                if (rise) begin
                    lba <= lba + 32'd1;
                    if (sec == LAST) req <= 1'b0;
                end
                if (fall) sec <= sec + 4'd1;
            end
        end
    end

endmodule

// File: rtl/disk_track_loader.sv
// disk_track_loader: multi-drive track fetcher from HPS virtual disks into track RAM.
// Define WRITEBACK_EN to flush dirty tracks to the image before loading the new one.
module disk_track_loader
    import disk_loader_pkg::*;
#(
    parameter int NUM_DRIVES        = 2,
    parameter int SECTORS_PER_TRACK = 13,
    parameter int TRACK_W           = 6,
    parameter int WAIT_FULL         = 0
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic [NUM_DRIVES*TRACK_W-1:0]   track,
    input  logic [NUM_DRIVES-1:0]           img_mounted,
    input  logic [NUM_DRIVES-1:0]           img_present,
    input  logic [NUM_DRIVES-1:0]           track_dirty,
    output logic [31:0]                     sd_lba,
    output logic [NUM_DRIVES-1:0]           sd_rd,
    output logic [NUM_DRIVES-1:0]           sd_wr,
    input  logic [NUM_DRIVES-1:0]           sd_ack,
    output logic [$clog2(NUM_DRIVES):0]     ram_drive,
    output logic [3:0]                      ram_sec,
    output logic                            cpu_wait,
    output logic                            busy
);

    localparam int DW = $clog2(NUM_DRIVES) + 1;

    state_t                state;
    logic [DW-1:0]         last;
    logic [TRACK_W-1:0]    new_trk;
    logic [TRACK_W-1:0]    trk_sel;
    logic [TRACK_W-1:0]    cur_sel;
    logic [TRACK_W-1:0]    cur_track [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] valid;
    logic [NUM_DRIVES-1:0] mount_seen;
    logic [NUM_DRIVES-1:0] dirty;
    logic [NUM_DRIVES-1:0] pend;
    logic [NUM_DRIVES-1:0] sel_oh;
    logic [NUM_DRIVES-1:0] drv_oh;
    logic                  any;
    logic                  flush_sel;
    logic                  start;
    logic                  req;
    logic                  first_fall;
    logic                  done;
    logic [31:0]           base_lba;
    int                    sel;

    assign drv_oh = NUM_DRIVES'(1) << ram_drive;
    assign busy   = state != ST_IDLE;
    assign sd_rd  = (state == ST_READ && req) ? drv_oh : '0;
    assign start  = (state == ST_IDLE && any) || (state == ST_FLUSH && done);
    assign base_lba = (state == ST_IDLE) ? track_lba(SECTORS_PER_TRACK, 32'(flush_sel ? cur_sel : trk_sel))
                                         : track_lba(SECTORS_PER_TRACK, 32'(new_trk));

`ifdef WRITEBACK_EN
    assign sd_wr = (state == ST_FLUSH && req) ? drv_oh : '0;

    // Controller writes mark a track dirty unless that drive is mid-transfer; a flush cleans it
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= '0;
        end else begin
            for (int d = 0; d < NUM_DRIVES; d++) begin
                if (state == ST_FLUSH && done && drv_oh[d]) dirty[d] <= 1'b0;
                else if (track_dirty[d] && !(busy && drv_oh[d])) dirty[d] <= 1'b1;
            end
        end
    end
`else
    logic unused_dirty;
    assign sd_wr        = '0;
    assign dirty        = '0;
    assign unused_dirty = ^track_dirty;
`endif

    // A drive needs a load when it has an image and its RAM copy is stale or freshly mounted
    always_comb begin
        pend = '0;
        for (int d = 0; d < NUM_DRIVES; d++)
            pend[d] = img_present[d] & (~valid[d] | (cur_track[d] != track[d*TRACK_W +: TRACK_W]) | mount_seen[d]);
    end

    // Round-robin pick: the pending drive closest after the last one served wins
    always_comb begin
        any       = 1'b0;
        sel       = 0;
        trk_sel   = '0;
        cur_sel   = '0;
        flush_sel = 1'b0;
        sel_oh    = '0;
        for (int i = NUM_DRIVES; i >= 1; i--)
            for (int d = 0; d < NUM_DRIVES; d++)
                if (pend[d] && d == (int'(last) + i) % NUM_DRIVES) begin
                    any = 1'b1;
                    sel = d;
                end
        for (int d = 0; d < NUM_DRIVES; d++)
            if (d == sel) begin
                trk_sel   = track[d*TRACK_W +: TRACK_W];
                cur_sel   = cur_track[d];
                flush_sel = dirty[d] & valid[d];
                sel_oh[d] = 1'b1;
            end
    end

    sd_block_seq #(
        .SECTORS_PER_TRACK(SECTORS_PER_TRACK)
    ) u_seq (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .base_lba  (base_lba),
        .ack       (|(sd_ack & drv_oh)),
        .req       (req),
        .lba       (sd_lba),
        .sec       (ram_sec),
        .first_fall(first_fall),
        .done      (done)
    );

    // Job sequencing and per-drive bookkeeping; absent drives track the head without SD traffic
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last       <= DW'(NUM_DRIVES - 1);
            ram_drive  <= '0;
            new_trk    <= '0;
            cpu_wait   <= 1'b0;
            valid      <= '0;
            mount_seen <= '0;
            for (int d = 0; d < NUM_DRIVES; d++) cur_track[d] <= '0;
        end else begin
            mount_seen <= (mount_seen & ~((state == ST_IDLE && any) ? sel_oh : '0)) | img_mounted;
            for (int d = 0; d < NUM_DRIVES; d++) begin
                if (!img_present[d]) begin
                    cur_track[d] <= track[d*TRACK_W +: TRACK_W];
                    valid[d]     <= 1'b1;
                end else if (state == ST_READ && done && drv_oh[d]) begin
                    cur_track[d] <= new_trk;
                    valid[d]     <= 1'b1;
                end
            end
            if (state == ST_IDLE && any) begin
                ram_drive <= DW'(sel);
                last      <= DW'(sel);
                new_trk   <= trk_sel;
                cpu_wait  <= 1'b1;
                state     <= flush_sel ? ST_FLUSH : ST_READ;
            end else if (state == ST_FLUSH && done) begin
                state <= ST_READ;
            end else if (state == ST_READ && done) begin
                cpu_wait <= 1'b0;
                state    <= ST_IDLE;
            end else if (state == ST_READ && first_fall && WAIT_FULL == 0) begin
                cpu_wait <= 1'b0;
            end
        end
    end

endmodule
